uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//   Shares one UART serial transmitter between N_REQ byte producers.
//   A round-robin arbiter picks one requester. The block builds the frame:
//   start bit, 8 data bits LSB first, optional parity bit, stop bit.
//   A divider generates the 16x oversample baud tick, and the block shifts the frame out on txd.
//   Sits between on-chip byte sources and the board-level TX pin.
// PARAMETERS
//   CLK_HZ      100_000_000  system clock frequency (Hz)
//   BAUD        115200       line rate (bit/s)
//   OVERSAMPLE  16           baud ticks per bit
//   N_REQ       4            number of requesters (2..8)
//   PARITY_EN   1            1: 11-bit frame with parity; 0: 10-bit frame
//   PARITY_ODD  0            0: even parity; 1: odd parity (ignored if PARITY_EN=0)
// PORTS
//   sclk        in   1          system clock, rising edge
//   rst_n       in   1          asynchronous active-low reset
//   req         in   N_REQ      per-requester "byte valid", level
//   data        in   8*N_REQ    requester i byte at data[8*i+7:8*i]
//   gnt         out  N_REQ      one-hot, 1-cycle pulse; the byte is consumed that cycle
//   grant_id    out  clog2(N)   index of the last granted requester
//   busy        out  1          high from the grant cycle to the end of the stop bit
//   frame_done  out  1          1-cycle pulse when the stop bit period ends
//   txd         out  1          serial output, idle high
// BEHAVIOUR
//   Clock and reset: one clock, sclk. Reset is asynchronous and active-low on rst_n.
//   Reset values: txd=1, gnt=0, busy=0, frame_done=0, grant_id=0.
//     Round-robin pointer resets so req[0] has top priority.
//     Divider and bit counters reset to 0, and the FSM resets to IDLE.
//   Divider: DIV = CLK_HZ/(BAUD*OVERSAMPLE), integer division.
//     Defaults give DIV=54, so one bit lasts DIV*OVERSAMPLE = 864 sclk.
//     DIV<1 is an elaboration error ($error).
//     The tick counter counts 0..DIV-1. tick=1 when count==DIV-1, then the counter wraps.
//     The counter is cleared on grant so that bit timing aligns to the frame.
//   FSM IDLE:
//     If |req is true, pulse gnt for the winner.
//     Winner = first requester with req set, searching from (last winner+1) mod N_REQ with wrap.
//     In the same cycle: latch data, update grant_id, set busy=1, go to SEND.
//     If no req: stay in IDLE with txd=1.
//   FSM SEND:
//     txd drives frame bit k, k=0..NBITS-1; NBITS = 11 if PARITY_EN else 10.
//     Bit order: start 0; d[0]..d[7]; parity (^d ^ PARITY_ODD); stop 1.
//     The first sclk after the grant already shows the start bit.
//     k advances after OVERSAMPLE ticks.
//     In the last cycle of the stop bit: frame_done=1, then go to IDLE with busy=0.
//   Back-to-back frames: IDLE evaluates req one cycle after frame_done.
//     This gives exactly one idle sclk with txd=1 between frames.
//   Grants and requests:
//     A requester whose req drops before it is granted receives no gnt.
//     req is ignored while busy. Changing data after gnt does not affect the frame in flight.
//   Reset mid-frame: txd returns to 1 asynchronously and the frame is abandoned.
//     No frame_done is issued, and arbitration restarts from req[0].
//   txd is registered (no glitches); all outputs change only on the sclk edge, except under reset.
// TESTING
//   Reset: hold rst_n=0 with req=4'hF -> txd=1, gnt=0, busy=0, grant_id=0 throughout.
//   Single frame: req[0]=1, data0=8'hA5, defaults -> gnt=4'b0001 for 1 cycle.
//     txd = 0,1,0,1,0,0,1,0,1,0(par),1, with each bit 864 cycles.
//     frame_done pulses 11*864 cycles after the start bit begins.
//   Fairness: req=4'hF held -> grant sequence 0,1,2,3,0,... with 1 idle cycle between frames.
//   Mid-frame reset: pulse rst_n low during d[4] of a frame from req[2], then req=4'b1101
//     -> txd=1 immediately, no frame_done, next grant goes to requester 0.
//   PARITY_EN=0: data 8'hFF -> 10-bit frame (0, eight 1s, 1) lasting 8640 cycles.
//   PARITY_ODD=1: data 8'h00 -> parity bit = 1.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between N_REQ byte producers using a round-robin arbiter.
// The frame is start, 8 data bits LSB first, optional parity, then stop, timed by a 16x oversample divider.
module uart_tx_scheduler #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int N_REQ      = 4,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                     sclk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [8*N_REQ-1:0]       data,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     txd
);
    localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int NBITS = (PARITY_EN != 0) ? 11 : 10;
    localparam int IDW   = $clog2(N_REQ);
    localparam int CW    = $clog2(DIV + 2);
    localparam int OW    = $clog2(OVERSAMPLE + 2);
    localparam int BW    = 4;

    if (DIV < 1) begin : g_div_check
        $error("uart_tx_scheduler: CLK_HZ/(BAUD*OVERSAMPLE) must be at least 1");
    end

    typedef enum logic {IDLE, SEND} state_t;
    state_t state_q, state_d;

    logic [CW-1:0]    div_q, div_d;
    logic [OW-1:0]    os_q, os_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [9:0]       frame_q, frame_d;
    logic             txd_q, txd_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]   gid_q, gid_d;
    logic [IDW-1:0]   last_q, last_d;
    logic             busy_q, busy_d;

    logic             win_found;
    logic [IDW-1:0]   win_idx, cand;
    logic [7:0]       win_byte;
    logic             par_bit, grant, tick, bit_end, frame_end;

    // Search starts one past the last winner and wraps, giving round-robin order.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IDW'((int'(last_q) + 1 + i) % N_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_byte  = data[{win_idx, 3'b000} +: 8];
    // With parity disabled this slot carries the stop bit, so the shift register still works.
    assign par_bit   = (PARITY_EN != 0) ? ((^win_byte) ^ (PARITY_ODD != 0)) : 1'b1;
    assign grant     = (state_q == IDLE) && win_found;
    assign tick      = (div_q == CW'(DIV - 1));
    assign bit_end   = tick && (os_q == OW'(OVERSAMPLE - 1));
    assign frame_end = (state_q == SEND) && bit_end && (bit_q == BW'(NBITS - 1));

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_found) state_d = SEND;
            SEND:    if (frame_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d      = '0;
        busy_d     = (state_d == SEND);
        frame_done = frame_end;
        if (grant) begin
            gnt_d = N_REQ'(1) << win_idx;
        end
    end

    // The start bit goes straight to txd; frame_q holds the remaining bits, LSB next.
    always_comb begin
        div_d   = div_q;
        os_d    = os_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        txd_d   = txd_q;
        gid_d   = gid_q;
        last_d  = last_q;
        if (grant) begin
            div_d   = '0;
            os_d    = '0;
            bit_d   = '0;
            frame_d = {1'b1, par_bit, win_byte};
            txd_d   = 1'b0;
            gid_d   = win_idx;
            last_d  = win_idx;
        end else if (state_q == SEND) begin
            if (!tick) begin
                div_d = div_q + CW'(1);
            end else begin
                div_d = '0;
                if (!bit_end) begin
                    os_d = os_q + OW'(1);
                end else begin
                    os_d    = '0;
                    bit_d   = bit_q + BW'(1);
                    txd_d   = frame_end ? 1'b1 : frame_q[0];
                    frame_d = {1'b1, frame_q[9:1]};
                end
            end
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            os_q   <= '0;
            bit_q  <= '0;
            txd_q  <= 1'b1;
            gnt_q  <= '0;
            gid_q  <= '0;
            last_q <= IDW'(N_REQ - 1);
            busy_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            os_q   <= os_d;
            bit_q  <= bit_d;
            txd_q  <= txd_d;
            gnt_q  <= gnt_d;
            gid_q  <= gid_d;
            last_q <= last_d;
            busy_q <= busy_d;
        end
    end

    always_ff @(posedge sclk) begin
        frame_q <= frame_d;
    end

    assign gnt      = gnt_q;
    assign grant_id = gid_q;
    assign busy     = busy_q;
    assign txd      = txd_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: default, no-parity and odd-parity (fast divider) instances.
module tb_uart_tx_scheduler;
    logic sclk = 1'b0;
    logic rst_n;
    always #5 sclk = ~sclk;

    logic [3:0]  req_m, req_n, req_p;
    logic [31:0] data_m, data_n, data_p;
    logic [3:0]  gnt_m, gnt_n, gnt_p;
    logic [1:0]  gid_m, gid_n, gid_p;
    logic        busy_m, busy_n, busy_p;
    logic        fd_m, fd_n, fd_p;
    logic        txd_m, txd_n, txd_p;

    uart_tx_scheduler dut_m (
        .sclk(sclk), .rst_n(rst_n), .req(req_m), .data(data_m), .gnt(gnt_m),
        .grant_id(gid_m), .busy(busy_m), .frame_done(fd_m), .txd(txd_m)
    );

    uart_tx_scheduler #(.PARITY_EN(0)) dut_n (
        .sclk(sclk), .rst_n(rst_n), .req(req_n), .data(data_n), .gnt(gnt_n),
        .grant_id(gid_n), .busy(busy_n), .frame_done(fd_n), .txd(txd_n)
    );

    // 7_372_800 / (115200*16) = 4 clocks per tick, 64 clocks per bit.
    uart_tx_scheduler #(.CLK_HZ(7_372_800), .PARITY_ODD(1)) dut_p (
        .sclk(sclk), .rst_n(rst_n), .req(req_p), .data(data_p), .gnt(gnt_p),
        .grant_id(gid_p), .busy(busy_p), .frame_done(fd_p), .txd(txd_p)
    );

    int n_run  = 0;
    int n_fail = 0;
    int fdc0 = 0, fdc1 = 0, fdc2 = 0;

    always @(posedge sclk) begin
        if (fd_m === 1'b1) fdc0 <= fdc0 + 1;
        if (fd_n === 1'b1) fdc1 <= fdc1 + 1;
        if (fd_p === 1'b1) fdc2 <= fdc2 + 1;
    end

    typedef struct {
        int   sel;
        int   off;
        logic txd;
        logic busy;
        logic fd;
    } vec_t;
    vec_t vec[$];

    task automatic add(input int sel, input int off, input logic t, input logic b, input logic f);
        vec_t v;
        v.sel = sel; v.off = off; v.txd = t; v.busy = b; v.fd = f;
        vec.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int sel, input logic r, input logic [7:0] b);
        case (sel)
            0:       begin req_m = {3'b000, r}; data_m = {24'h0, b}; end
            1:       begin req_n = {3'b000, r}; data_n = {24'h0, b}; end
            default: begin req_p = {3'b000, r}; data_p = {24'h0, b}; end
        endcase
    endtask

    task automatic get(input int sel, output logic t, output logic b, output logic f,
                       output logic [3:0] g, output int fc);
        case (sel)
            0:       begin t = txd_m; b = busy_m; f = fd_m; g = gnt_m; fc = fdc0; end
            1:       begin t = txd_n; b = busy_n; f = fd_n; g = gnt_n; fc = fdc1; end
            default: begin t = txd_p; b = busy_p; f = fd_p; g = gnt_p; fc = fdc2; end
        endcase
    endtask

    // Requester 0 of the selected instance sends one byte; table rows are checked at their offsets.
    task automatic run_frame(input int sel, input logic [7:0] b);
        logic t, bz, f;
        logic [3:0] g;
        int fc0, fc1, cur;
        @(negedge sclk);
        set_req(sel, 1'b1, b);
        @(negedge sclk);
        get(sel, t, bz, f, g, fc0);
        chk($sformatf("frame%0d_gnt", sel), {28'h0, g}, 32'h1);
        set_req(sel, 1'b0, ~b);
        cur = 0;
        for (int i = 0; i < vec.size(); i++) begin
            if (vec[i].sel == sel) begin
                repeat (vec[i].off - cur) @(negedge sclk);
                cur = vec[i].off;
                get(sel, t, bz, f, g, fc1);
                chk($sformatf("frame%0d_off%0d txd/busy/fd", sel, vec[i].off),
                    {29'h0, t, bz, f}, {29'h0, vec[i].txd, vec[i].busy, vec[i].fd});
            end
        end
        get(sel, t, bz, f, g, fc1);
        chk($sformatf("frame%0d_done_pulses", sel), fc1 - fc0, 1);
    endtask

    task automatic wait_gnt_m(input int budget, output int id);
        int c;
        c  = 0;
        id = -1;
        while (gnt_m == 4'b0 && c < budget) begin
            @(negedge sclk);
            c++;
        end
        if (gnt_m == 4'b0) begin
            n_run++;
            n_fail++;
            $display("FAIL grant_timeout: got no gnt expected one within %0d cycles", budget);
        end else begin
            for (int i = 0; i < 4; i++) if (gnt_m[i]) id = i;
        end
    endtask

    task automatic wait_fd_m(input int budget);
        int c;
        c = 0;
        while (fd_m !== 1'b1 && c < budget) begin
            @(negedge sclk);
            c++;
        end
        if (fd_m !== 1'b1) begin
            n_run++;
            n_fail++;
            $display("FAIL frame_done_timeout: got none expected one within %0d cycles", budget);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int id, saved;

        // A5 with even parity: 0 | 1,0,1,0,0,1,0,1 | 0 | 1, 864 clocks per bit.
        add(0, 0,    1'b0, 1'b1, 1'b0);
        add(0, 1,    1'b0, 1'b1, 1'b0);
        add(0, 432,  1'b0, 1'b1, 1'b0);
        add(0, 863,  1'b0, 1'b1, 1'b0);
        add(0, 864,  1'b1, 1'b1, 1'b0);
        add(0, 1296, 1'b1, 1'b1, 1'b0);
        add(0, 2160, 1'b0, 1'b1, 1'b0);
        add(0, 3024, 1'b1, 1'b1, 1'b0);
        add(0, 3888, 1'b0, 1'b1, 1'b0);
        add(0, 4752, 1'b0, 1'b1, 1'b0);
        add(0, 5616, 1'b1, 1'b1, 1'b0);
        add(0, 6480, 1'b0, 1'b1, 1'b0);
        add(0, 7344, 1'b1, 1'b1, 1'b0);
        add(0, 8208, 1'b0, 1'b1, 1'b0);
        add(0, 9072, 1'b1, 1'b1, 1'b0);
        add(0, 9502, 1'b1, 1'b1, 1'b0);
        add(0, 9503, 1'b1, 1'b1, 1'b1);
        add(0, 9504, 1'b1, 1'b0, 1'b0);
        // FF without parity: 0, nine 1s, 8640 clocks in total.
        add(1, 0,    1'b0, 1'b1, 1'b0);
        add(1, 863,  1'b0, 1'b1, 1'b0);
        add(1, 864,  1'b1, 1'b1, 1'b0);
        add(1, 4752, 1'b1, 1'b1, 1'b0);
        add(1, 7344, 1'b1, 1'b1, 1'b0);
        add(1, 8208, 1'b1, 1'b1, 1'b0);
        add(1, 8638, 1'b1, 1'b1, 1'b0);
        add(1, 8639, 1'b1, 1'b1, 1'b1);
        add(1, 8640, 1'b1, 1'b0, 1'b0);
        // 00 with odd parity, 64 clocks per bit: parity bit 9 is 1.
        add(2, 32,  1'b0, 1'b1, 1'b0);
        add(2, 64,  1'b0, 1'b1, 1'b0);
        add(2, 544, 1'b0, 1'b1, 1'b0);
        add(2, 575, 1'b0, 1'b1, 1'b0);
        add(2, 576, 1'b1, 1'b1, 1'b0);
        add(2, 608, 1'b1, 1'b1, 1'b0);
        add(2, 672, 1'b1, 1'b1, 1'b0);
        add(2, 703, 1'b1, 1'b1, 1'b1);
        add(2, 704, 1'b1, 1'b0, 1'b0);

        rst_n  = 1'b0;
        req_m  = 4'hF;
        req_n  = 4'h0;
        req_p  = 4'h0;
        data_m = 32'h0;
        data_n = 32'h0;
        data_p = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge sclk);
            chk($sformatf("reset%0d txd/busy/fd", i), {29'h0, txd_m, busy_m, fd_m}, 32'h4);
            chk($sformatf("reset%0d gnt", i), {28'h0, gnt_m}, 32'h0);
            chk($sformatf("reset%0d grant_id", i), {30'h0, gid_m}, 32'h0);
        end
        req_m = 4'h0;
        rst_n = 1'b1;
        repeat (2) @(negedge sclk);

        run_frame(0, 8'hA5);
        chk("frame0_grant_id", {30'h0, gid_m}, 32'h0);
        run_frame(1, 8'hFF);
        run_frame(2, 8'h00);

        @(negedge sclk);
        rst_n = 1'b0;
        @(negedge sclk);
        rst_n = 1'b1;

        req_m  = 4'hF;
        data_m = 32'h44332211;
        wait_gnt_m(20, id);
        chk("fair_first_id", id, 0);
        chk("fair_first_grant_id", {30'h0, gid_m}, 32'h0);
        for (int g = 1; g <= 4; g++) begin
            wait_fd_m(12000);
            @(negedge sclk);
            chk($sformatf("fair_gap%0d busy/txd/gnt", g), {26'h0, busy_m, txd_m, gnt_m}, 32'h10);
            @(negedge sclk);
            chk($sformatf("fair_gnt%0d", g), {28'h0, gnt_m}, 32'h1 << (g % 4));
            chk($sformatf("fair_grant_id%0d", g), {30'h0, gid_m}, g % 4);
        end

        @(negedge sclk);
        rst_n = 1'b0;
        req_m = 4'h0;
        @(negedge sclk);
        rst_n  = 1'b1;
        req_m  = 4'b0100;
        data_m = 32'h00EF0000;
        wait_gnt_m(5, id);
        chk("mid_first_id", id, 2);
        req_m = 4'h0;
        repeat (5 * 864 + 432) @(negedge sclk);
        chk("mid_d4_txd", {31'h0, txd_m}, 32'h0);
        saved = fdc0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_async_txd", {31'h0, txd_m}, 32'h1);
        chk("mid_async_busy", {31'h0, busy_m}, 32'h0);
        @(negedge sclk);
        rst_n = 1'b1;
        req_m = 4'b1101;
        wait_gnt_m(5, id);
        chk("mid_next_id", id, 0);
        chk("mid_next_gnt", {28'h0, gnt_m}, 32'h1);
        chk("mid_next_grant_id", {30'h0, gid_m}, 32'h0);
        chk("mid_no_frame_done", fdc0, saved);
        chk("aux_grant_ids", {28'h0, gid_n, gid_p}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
